// File: rtl/dsram_responder_pkg.sv
// Shared types and constants for the data-SRAM responder.
package dsram_responder_pkg;

  // Responder FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dsram_state_t;

  // Memory-op write-enable patterns used by the MEM stage.
  localparam logic [3:0] WEN_NONE = 4'b0000;
  localparam logic [3:0] WEN_WORD = 4'b1111;

  // Access sizes carried on data_sram_rlen.
  localparam logic [1:0] RLEN_B = 2'd0;
  localparam logic [1:0] RLEN_H = 2'd1;
  localparam logic [1:0] RLEN_W = 2'd2;

  // A word access needs addr[1:0]==0.
  // A half-word access needs addr[0]==0.
  // Byte accesses are always aligned.
  function automatic logic is_misaligned(input logic [1:0] rlen,
                                         input logic [1:0] addr_lo);
    return ((rlen == RLEN_W) && (addr_lo != 2'b00)) ||
           ((rlen == RLEN_H) && addr_lo[0]);
  endfunction

endpackage

// File: rtl/dsram_responder_bram_be.sv
// Single-port byte-enabled block RAM with a registered, read-first output.
// There is deliberately no reset, so contents survive a core reset.
module bram_be #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rdata_reg;

  // Byte-lane writes; the old word is captured in the same edge (read-first).
  always_ff @(posedge clk) begin
    if (en) begin
      rdata_reg <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dsram_responder.sv
// Responder for the MEM-stage data-SRAM interface.
// It accepts one request, waits WAIT_CYCLES, then commits the write.
// The completion cycle returns the old word together with an ok pulse.
module dsram_responder
  import dsram_responder_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [1:0]  data_sram_rlen,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_ok,
  output logic        data_sram_err,
  output logic        data_sram_stall
);

  localparam logic [2:0] CNT_INIT = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

  dsram_state_t      state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic [ADDR_W+1:0] addr_reg;
  logic [3:0]        wen_reg;
  logic [31:0]       wdata_reg;
  logic [1:0]        rlen_reg;
  logic              ok_reg;
  logic              err_reg;

  logic              accept;
  logic              go_resp;
  logic [ADDR_W+1:0] req_addr;
  logic [3:0]        req_wen;
  logic [31:0]       req_wdata;
  logic [1:0]        req_rlen;
  logic              misaligned;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [31:0]       mem_rdata;
  logic              addr_hi_unused;

  // Upper address bits are ignored, so the memory aliases.
  assign addr_hi_unused = ^data_sram_addr[31:ADDR_W+2];

  assign accept = (state_reg == S_IDLE) && data_sram_en;

  // The memory is accessed on the edge that enters S_RESP.
  // With zero wait states, that edge is the accept edge itself.
  assign go_resp = (accept && (WAIT_CYCLES == 0)) ||
                   ((state_reg == S_WAIT) && (cnt_reg == 3'd0));

  // In S_IDLE the request comes straight from the ports.
  // In every other state it comes from the latch.
  assign req_addr  = (state_reg == S_IDLE) ? data_sram_addr[ADDR_W+1:0] : addr_reg;
  assign req_wen   = (state_reg == S_IDLE) ? data_sram_wen   : wen_reg;
  assign req_wdata = (state_reg == S_IDLE) ? data_sram_wdata : wdata_reg;
  assign req_rlen  = (state_reg == S_IDLE) ? data_sram_rlen  : rlen_reg;

  assign misaligned = is_misaligned(req_rlen, req_addr[1:0]);

  // Reset cancels a pending write, and a misaligned access never writes.
  assign mem_en = go_resp && !rst;
  assign mem_we = (mem_en && !misaligned) ? req_wen : WEN_NONE;

  bram_be #(
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (req_addr[ADDR_W+1:2]),
    .wdata (req_wdata),
    .rdata (mem_rdata)
  );

  // Next-state and wait-counter logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (data_sram_en) begin
          if (WAIT_CYCLES == 0) begin
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        // Continue even if en drops, because a latched request always completes.
        if (cnt_reg == 3'd0) begin
          state_next = S_RESP;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  // State, request latch and registered completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= 3'd0;
      ok_reg    <= 1'b0;
      err_reg   <= 1'b0;
      addr_reg  <= '0;
      wen_reg   <= 4'd0;
      wdata_reg <= 32'd0;
      rlen_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ok_reg    <= go_resp;
      err_reg   <= go_resp && misaligned;
      if (accept) begin
        addr_reg  <= data_sram_addr[ADDR_W+1:0];
        wen_reg   <= data_sram_wen;
        wdata_reg <= data_sram_wdata;
        rlen_reg  <= data_sram_rlen;
      end
    end
  end

  // The RAM output register has no reset.
  // Masking it with ok keeps rdata at zero outside a completion.
  assign data_sram_rdata = ok_reg ? mem_rdata : 32'd0;
  assign data_sram_ok    = ok_reg;
  assign data_sram_err   = err_reg;
  assign data_sram_stall = data_sram_en && !ok_reg;

endmodule
